sr_cell_bank: RTL
=================

Name: sr_cell_bank

Overview:
- Downstream storage stage for the SR conditioning logic.
- Consumes the conditioned set/reset pair (s_setup, r_setup) and applies it, on a write strobe, to one of DEPTH addressed SR storage bits.
- Flags forbidden SR combinations with a conflict pulse and a saturating count.
- Exposes the bank in parallel, and through a serial readout engine with a start/busy/done handshake for pin-limited output.

Parameters:
- DEPTH, 8, number of SR storage bits; 2 <= DEPTH <= 2**AW.
- AW, 3, address width.
- CW, 8, width of the saturating conflict counter.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe; applies s_setup/r_setup to bit wr_addr this cycle.
- wr_addr  in  AW  target bit index.
- s_setup  in  1  conditioned set request.
- r_setup  in  1  conditioned reset request.
- q  out  DEPTH  current state of all storage bits.
- conflict  out  1  one-cycle pulse: write with s_setup=r_setup=1.
- addr_err  out  1  one-cycle pulse: write with wr_addr >= DEPTH.
- conflict_cnt  out  CW  saturating count of conflict events.
- rd_start  in  1  request serial readout.
- rd_busy  out  1  high while readout is shifting.
- rd_bit  out  1  serial data, LSB (bit 0) first.
- rd_valid  out  1  rd_bit is valid this cycle.
- rd_done  out  1  one-cycle pulse after the last bit.

Behaviour:
Reset:
- rst_n low asynchronously clears q, conflict, addr_err, conflict_cnt, rd_busy, rd_bit, rd_valid, rd_done and the shift register.
- FSM goes to IDLE.
- Reset asserted mid-readout aborts it; no rd_done is issued.

Write path (registered, 1-cycle latency: q updates on the edge where wr_en=1):
- s=1, r=0: q[wr_addr] <= 1.
- s=0, r=1: q[wr_addr] <= 0.
- s=0, r=0: hold.
- s=1, r=1: hold; conflict=1 next cycle; conflict_cnt increments, saturating at 2**CW-1 (no wrap).
- wr_addr >= DEPTH: no bit changes; addr_err=1 next cycle.
  - If s=r=1 on the same out-of-range write, only addr_err pulses; conflict_cnt is unchanged.
- wr_en=0: s_setup/r_setup are ignored entirely; no pulses.
- conflict and addr_err are registered single-cycle pulses; back-to-back faulting writes give consecutive high cycles.

Readout FSM:
- States: IDLE, SHIFT, DONE.
- IDLE:
  - rd_start=1 -> snapshot q into shift register (value of q before any write on the same edge); idx <= 0; go to SHIFT.
  - rd_busy=1 from the next cycle.
- SHIFT:
  - Each cycle: rd_valid=1, rd_bit=shift[0], then shift right and idx++.
  - After DEPTH valid cycles -> DONE.
  - rd_start is ignored.
  - Writes update q but not the snapshot.
- DONE:
  - One cycle: rd_done=1, rd_busy=0, rd_valid=0; return to IDLE.
  - rd_start here is ignored; rd_start in the following IDLE cycle is accepted.
- Total: rd_start edge -> first rd_valid 1 cycle later; DEPTH valid cycles; rd_done in cycle DEPTH+1.
- rd_bit is 0 whenever rd_valid=0.

Decomposition:
- Shared package (sr_pkg):
  - rd_state_t enum {IDLE, SHIFT, DONE}.
  - Defaults for DEPTH/AW/CW.
  - SR code constants: SR_HOLD=2'b00, SR_CLR=2'b01, SR_SET=2'b10, SR_BAD=2'b11 (encoding {s,r}).
- Sub-module sr_readout_shifter: the FSM, snapshot, shift register and handshake, parameterised by DEPTH.
- The top level holds the bit array, write decode, error pulses and counter.

Test Plan:
- Reset, then write addr 3 with s=1,r=0, then addr 5 with s=1,r=0 -> q=8'h28 one cycle after each respective strobe; conflict and addr_err stay 0.
- q=8'h28, write addr 3 with s=0,r=1; then addr 5 with s=1,r=1 -> q=8'h20; conflict pulses once; conflict_cnt=1; q[5] unchanged.
- CW=2: five s=r=1 writes -> conflict_cnt 1,2,3,3,3; conflict high on five consecutive cycles when the writes are back-to-back.
- AW=4, DEPTH=8: write addr 9 with s=1,r=0 -> addr_err pulse; q unchanged.
- q=8'hA5, pulse rd_start:
  - rd_valid high for 8 cycles with rd_bit 1,0,1,0,0,1,0,1, then rd_done for 1 cycle.
  - A write to bit 1 during SHIFT changes q but not the serial data.
  - rd_start during SHIFT is ignored.
- Assert rst_n=0 at the 4th SHIFT cycle -> all outputs 0 immediately; no rd_done; a new rd_start after release reads the cleared bank (all zeros).

Source files
------------

// File: rtl/sr_pkg.sv
// Shared types and constants for the SR storage bank and its serial readout.
package sr_pkg;

  localparam int SR_DEPTH = 8;
  localparam int SR_AW    = 3;
  localparam int SR_CW    = 8;

  // {s, r} request encodings
  localparam logic [1:0] SR_HOLD = 2'b00;
  localparam logic [1:0] SR_CLR  = 2'b01;
  localparam logic [1:0] SR_SET  = 2'b10;
  localparam logic [1:0] SR_BAD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } rd_state_t;

endpackage

// File: rtl/sr_readout_shifter.sv
// Serial readout engine: snapshots the bank on rd_start and shifts it out LSB first.
module sr_readout_shifter
  import sr_pkg::*;
#(
  parameter int DEPTH = SR_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_start,
  input  logic [DEPTH-1:0] q,
  output logic             rd_busy,
  output logic             rd_bit,
  output logic             rd_valid,
  output logic             rd_done
);

  localparam int IW = $clog2(DEPTH + 1);

  rd_state_t        state;
  logic [DEPTH-1:0] shift;
  logic [IW-1:0]    idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shift <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: if (rd_start) begin
          // q here is the pre-edge value, so a same-edge write is not captured
          shift <= q;
          idx   <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          shift <= shift >> 1;
          idx   <= idx + 1'b1;
          if (idx == IW'(DEPTH - 1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so reset clears them immediately
  assign rd_valid = (state == SHIFT);
  assign rd_busy  = rd_valid;
  assign rd_bit   = rd_valid & shift[0];
  assign rd_done  = (state == DONE);

endmodule

// File: rtl/sr_cell_bank.sv
// Addressed bank of SR storage bits with conflict/address error flags and serial readout.
module sr_cell_bank
  import sr_pkg::*;
#(
  parameter int DEPTH = SR_DEPTH,
  parameter int AW    = SR_AW,
  parameter int CW    = SR_CW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic             s_setup,
  input  logic             r_setup,
  output logic [DEPTH-1:0] q,
  output logic             conflict,
  output logic             addr_err,
  output logic [CW-1:0]    conflict_cnt,
  input  logic             rd_start,
  output logic             rd_busy,
  output logic             rd_bit,
  output logic             rd_valid,
  output logic             rd_done
);

  logic [1:0] sr_code;
  logic       in_range;
  logic       wr_ok;
  logic       bad_wr;

  assign sr_code  = {s_setup, r_setup};
  assign in_range = 32'(wr_addr) < 32'(DEPTH);
  assign wr_ok    = wr_en & in_range;
  // Out-of-range writes report only addr_err, never a conflict
  assign bad_wr   = wr_ok & (sr_code == SR_BAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_addr == AW'(i)) begin
          case (sr_code)
            SR_SET:  q[i] <= 1'b1;
            SR_CLR:  q[i] <= 1'b0;
            SR_HOLD: q[i] <= q[i];
            default: q[i] <= q[i];
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict     <= 1'b0;
      addr_err     <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      conflict <= bad_wr;
      addr_err <= wr_en & ~in_range;
      if (bad_wr && !(&conflict_cnt)) conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

  sr_readout_shifter #(.DEPTH(DEPTH)) u_rd (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_start (rd_start),
    .q        (q),
    .rd_busy  (rd_busy),
    .rd_bit   (rd_bit),
    .rd_valid (rd_valid),
    .rd_done  (rd_done)
  );

endmodule
